// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared pipeline-stage types and constants
package pipe_pkg;

  // Occupancy-coded state: the encoding doubles as the number of held beats.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } pipe_state_e;

  localparam int CTRL_W_DEF = 5;

  // Bit positions inside the control field.
  localparam int MEMWR    = 0;
  localparam int JUMP     = 1;
  localparam int BRANCH   = 2;
  localparam int MEMTOREG = 3;
  localparam int REGWR    = 4;

  function automatic logic [1:0] state_occupancy(input pipe_state_e s);
    return s;
  endfunction

endpackage

// File: rtl/pipe_stage_reg_sat_counter.sv
// rtl/pipe_stage_reg_sat_counter.sv - saturating event counter with async clear
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Step by one on each requested event, pinning at the all-ones value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != CNT_MAX)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register, updated on the falling edge like the stage it observes.
  always_ff @(negedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - valid/ready pipeline stage register with optional skid entry
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int SKID   = 1,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  pipe_state_e       state_q;
  pipe_state_e       state_d;
  logic [DATA_W-1:0] main_data_q;
  logic [DATA_W-1:0] main_data_d;
  logic [CTRL_W-1:0] main_ctrl_q;
  logic [CTRL_W-1:0] main_ctrl_d;
  logic [DATA_W-1:0] skid_data_q;
  logic [DATA_W-1:0] skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q;
  logic [CTRL_W-1:0] skid_ctrl_d;
  logic              in_fire;
  logic              out_fire;
  logic              stall;

  assign out_valid = (state_q != EMPTY);

  // Skid mode decodes in_ready from state alone so out_ready never reaches it
  // combinationally; single-entry mode must look at out_ready to stream.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = (state_q != TWO);
    end else begin : g_single_ready
      assign in_ready = out_ready | ~out_valid;
    end
  endgenerate

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next state and register loads; flush wins and squashes every control field.
  always_comb begin
    state_d     = state_q;
    main_data_d = main_data_q;
    main_ctrl_d = main_ctrl_q;
    skid_data_d = skid_data_q;
    skid_ctrl_d = skid_ctrl_q;
    if (flush) begin
      state_d     = EMPTY;
      main_ctrl_d = '0;
      skid_ctrl_d = '0;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_d     = ONE;
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_data_d = in_data;
            main_ctrl_d = in_ctrl;
          end else if (in_fire && (SKID != 0)) begin
            state_d     = TWO;
            skid_data_d = in_data;
            skid_ctrl_d = in_ctrl;
          end else if (out_fire) begin
            state_d     = EMPTY;
            main_ctrl_d = '0;
          end
        end
        TWO: begin
          if (out_fire) begin
            state_d     = ONE;
            main_data_d = skid_data_q;
            main_ctrl_d = skid_ctrl_q;
            skid_ctrl_d = '0;
          end
        end
        default: begin
          state_d     = EMPTY;
          main_ctrl_d = '0;
          skid_ctrl_d = '0;
        end
      endcase
    end
  end

  // State, main and skid registers, captured on the falling edge.
  always_ff @(negedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= EMPTY;
      main_data_q <= '0;
      main_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      state_q     <= state_d;
      main_data_q <= main_data_d;
      main_ctrl_q <= main_ctrl_d;
      skid_data_q <= skid_data_d;
      skid_ctrl_q <= skid_ctrl_d;
    end
  end

  assign out_data  = main_data_q;
  assign out_ctrl  = out_valid ? main_ctrl_q : '0;
  assign occupancy = state_occupancy(state_q);
  assign stall     = out_valid & ~out_ready;

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk  (CLK),
    .clr_n(RST_N),
    .inc  (stall),
    .count(stall_cnt)
  );

endmodule
